pq_cmd_entry: RTL and testbench

Operator command front end for the 16-bit priority queue. Samples the key switches and the raw insert and remove push-buttons, then synchronizes, debounces and edge-detects the buttons. Issues one insert or remove command at a time to the queue core over a valid/ready handshake and waits for the removed key to return. Tracks queue occupancy so that illegal operations are refused locally, and presents the last key handled to the display path.

---
 rtl/pq_cmd_entry.sv | 195 +++++++++++++++++++
 tb/tb_pq_cmd_entry.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pq_cmd_entry.sv
// Operator command front end for the priority queue: button conditioning,
// one-at-a-time insert/remove command issue, occupancy tracking and display key.
module pq_cmd_entry #(
  parameter int unsigned KEY_W     = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [KEY_W-1:0]             sw,
  input  logic                         btn_ins,
  input  logic                         btn_rem,
  output logic                         cmd_valid,
  output logic                         cmd_op,
  output logic [KEY_W-1:0]             cmd_data,
  input  logic                         cmd_ready,
  input  logic                         rsp_valid,
  input  logic [KEY_W-1:0]             rsp_data,
  output logic [KEY_W-1:0]             last_key,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Button conditioning: bit 0 = insert, bit 1 = remove
  logic [1:0] btn_raw;
  logic [1:0] sync1_q;
  logic [1:0] sync2_q;
  logic [1:0] acc_q;
  logic [1:0] acc_d;
  logic [1:0] acc_dly_q;
  logic [1:0] pulse_c;
  logic       ins_p;
  logic       rem_p;

  assign btn_raw = {btn_rem, btn_ins};

  // Two-flop synchronizer and edge-detect delay for both buttons
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      acc_dly_q <= 2'b00;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      acc_dly_q <= acc_q;
    end
  end

  // Per-button debounce: count cycles the synchronized level disagrees with
  // the accepted level; accept it after DB_CYCLES consecutive cycles
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;

    // Debounce next-state
    always_comb begin
      db_cnt_d = db_cnt_q;
      acc_d[g] = acc_q[g];
      if (sync2_q[g] == acc_q[g]) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_MAX) begin
        db_cnt_d = '0;
        acc_d[g] = sync2_q[g];
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end

    // Debounce state
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        db_cnt_q <= '0;
        acc_q[g] <= 1'b0;
      end else begin
        db_cnt_q <= db_cnt_d;
        acc_q[g] <= acc_d[g];
      end
    end
  end

  assign pulse_c = acc_q & ~acc_dly_q;
  assign ins_p   = pulse_c[0];
  assign rem_p   = pulse_c[1];

  // Command FSM and datapath registers
  logic [1:0]       state_q, state_d;
  logic             op_q, op_d;
  logic [KEY_W-1:0] data_q, data_d;
  logic [KEY_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic             full_c;
  logic             empty_c;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);

  // Next-state and register updates for the command sequencer
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    last_d  = last_q;
    count_d = count_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ins_p && rem_p) begin
          err_d = 1'b1;
        end else if (ins_p) begin
          if (full_c) begin
            err_d = 1'b1;
          end else begin
            data_d  = sw;
            op_d    = 1'b0;
            state_d = S_ISSUE;
          end
        end else if (rem_p) begin
          if (empty_c) begin
            err_d = 1'b1;
          end else begin
            op_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        err_d = ins_p | rem_p;
        if (cmd_ready) begin
          if (!op_q) begin
            count_d = count_q + CNT_W'(1);
            last_d  = data_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        err_d = ins_p | rem_p;
        if (rsp_valid) begin
          last_d  = rsp_data;
          count_d = count_q - CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      data_q  <= '0;
      last_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      last_q  <= last_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Outputs are flops or direct decodes of flops
  assign cmd_valid = (state_q == S_ISSUE);
  assign cmd_op    = op_q;
  assign cmd_data  = data_q;
  assign last_key  = last_q;
  assign count     = count_q;
  assign full      = full_c;
  assign empty     = empty_c;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_pq_cmd_entry.sv
// Scoreboard bench for pq_cmd_entry with a small queue-core model.
module tb_pq_cmd_entry;

  localparam int unsigned KEY_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DB    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [KEY_W-1:0] sw = '0;
  logic             btn_ins = 1'b0;
  logic             btn_rem = 1'b0;
  logic             cmd_valid;
  logic             cmd_op;
  logic [KEY_W-1:0] cmd_data;
  logic             cmd_ready = 1'b0;
  logic             rsp_valid = 1'b0;
  logic [KEY_W-1:0] rsp_data = '0;
  logic [KEY_W-1:0] last_key;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             busy;
  logic             err;

  pq_cmd_entry #(.KEY_W(KEY_W), .DEPTH(DEPTH), .DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_ins(btn_ins), .btn_rem(btn_rem),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .last_key(last_key), .count(count), .full(full), .empty(empty),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard of expected commands, pushed at stimulus time
  logic             exp_op_q[$];
  logic [KEY_W-1:0] exp_data_q[$];
  // Keys the core model holds
  logic [KEY_W-1:0] mdl_q[$];

  int  rsp_delay = 3;
  bit  core_hold = 1'b0;
  int  err_seen  = 0;
  int  cmd_seen  = 0;

  // Monitor: err high cycles and cmd_valid rising edges
  initial begin
    logic cv_prev;
    cv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (err) err_seen++;
      if (cmd_valid && !cv_prev) cmd_seen++;
      cv_prev = cmd_valid;
    end
  end

  // Core model: ready 2 cycles after valid, response rsp_delay cycles after a remove handshake
  initial begin
    int               vcnt;
    int               rcnt;
    logic             hs_op;
    logic [KEY_W-1:0] hs_data;
    logic [KEY_W-1:0] rsp_key;
    logic             eop;
    logic [KEY_W-1:0] edata;
    int               mi;
    vcnt = 0; rcnt = 0; hs_op = 1'b0; hs_data = '0; rsp_key = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cmd_ready = 1'b0; rsp_valid = 1'b0; vcnt = 0; rcnt = 0;
        mdl_q.delete(); exp_op_q.delete(); exp_data_q.delete();
      end else begin
        rsp_valid = 1'b0;
        if (cmd_ready) begin
          cmd_ready = 1'b0;
          vcnt = 0;
          if (exp_op_q.size() == 0) begin
            chk("sb_unexpected_cmd", 32'(0), 32'(1));
          end else begin
            eop   = exp_op_q.pop_front();
            edata = exp_data_q.pop_front();
            chk("cmd_op", 32'(hs_op), 32'(eop));
            if (!eop) begin
              chk("cmd_data", 32'(hs_data), 32'(edata));
              mdl_q.push_back(hs_data);
            end else if (mdl_q.size() > 0) begin
              mi = 0;
              for (int i = 1; i < mdl_q.size(); i++)
                if (mdl_q[i] < mdl_q[mi]) mi = i;
              rsp_key = mdl_q[mi];
              mdl_q.delete(mi);
              rcnt = rsp_delay;
            end
          end
        end else if (cmd_valid) begin
          vcnt++;
          if (vcnt == 1) begin
            hs_op = cmd_op; hs_data = cmd_data;
          end else begin
            chk("hold_op", 32'(cmd_op), 32'(hs_op));
            chk("hold_data", 32'(cmd_data), 32'(hs_data));
          end
          if (vcnt >= 2 && !core_hold) cmd_ready = 1'b1;
        end
        if (rcnt > 0) begin
          rcnt--;
          if (rcnt == 0) begin
            rsp_valid = 1'b1;
            rsp_data  = rsp_key;
          end
        end
      end
    end
  end

  int               exp_cnt  = 0;
  int               exp_errs = 0;
  int               exp_cmds = 0;
  logic [KEY_W-1:0] exp_last = '0;

  task automatic press(input logic ins, input logic rem, input int len);
    @(negedge clk);
    btn_ins = ins; btn_rem = rem;
    repeat (len) @(negedge clk);
    btn_ins = 1'b0; btn_rem = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(exp_cnt));
    chk({tag, "_last"}, 32'(last_key), 32'(exp_last));
    chk({tag, "_full"}, 32'(full), 32'(exp_cnt == int'(DEPTH)));
    chk({tag, "_empty"}, 32'(empty), 32'(exp_cnt == 0));
    chk({tag, "_errs"}, 32'(err_seen), 32'(exp_errs));
    chk({tag, "_cmds"}, 32'(cmd_seen), 32'(exp_cmds));
  endtask

  task automatic do_ins(input logic [KEY_W-1:0] key, input string tag);
    bit legal;
    sw = key;
    legal = (exp_cnt < int'(DEPTH));
    if (legal) begin
      exp_op_q.push_back(1'b0); exp_data_q.push_back(key);
    end
    press(1'b1, 1'b0, 10);
    wait_idle();
    if (legal) begin
      exp_cnt++; exp_last = key; exp_cmds++;
    end else begin
      exp_errs++;
    end
    check_state(tag);
  endtask

  task automatic do_rem(input logic [KEY_W-1:0] key, input string tag);
    bit legal;
    legal = (exp_cnt > 0);
    if (legal) begin
      exp_op_q.push_back(1'b1); exp_data_q.push_back('0);
    end
    press(1'b0, 1'b1, 10);
    wait_idle();
    if (legal) begin
      exp_cnt--; exp_last = key; exp_cmds++;
    end else begin
      exp_errs++;
    end
    check_state(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("rst_cmd_data", 32'(cmd_data), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cmd_op", 32'(cmd_op), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    repeat (50) @(negedge clk);
    check_state("idle");

    // Bounce rejection: toggling every 2 cycles
    sw = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      btn_ins = ~i[0];
      repeat (2) @(negedge clk);
    end
    btn_ins = 1'b0;
    repeat (20) @(negedge clk);
    check_state("bounce");

    // Clean press inserts once, then removed again
    do_ins(16'hABCD, "press");
    do_rem(16'hABCD, "rem_abcd");

    // Fill to full, then overflow attempt
    do_ins(16'h0010, "fill1");
    do_ins(16'h0200, "fill2");
    do_ins(16'h3000, "fill3");
    do_ins(16'h0004, "fill4");
    do_ins(16'h5555, "overflow");

    // Drain, then underflow attempt
    do_rem(16'h0004, "rem1");
    do_rem(16'h0010, "rem2");
    do_rem(16'h0200, "rem3");
    do_rem(16'h3000, "rem4");
    do_rem(16'h0000, "underflow");

    // Remove pressed while the first remove waits for its response
    do_ins(16'h0055, "pre_busy");
    rsp_delay = 30;
    exp_op_q.push_back(1'b1); exp_data_q.push_back('0);
    press(1'b0, 1'b1, 8);
    chk("busy_in_wait", 32'(busy), 32'(1));
    press(1'b0, 1'b1, 8);
    wait_idle();
    exp_cnt--; exp_last = 16'h0055; exp_cmds++; exp_errs++;
    check_state("busy_drop");
    rsp_delay = 3;

    // Both buttons at once
    press(1'b1, 1'b1, 10);
    wait_idle();
    exp_errs++;
    check_state("simul");

    // Asynchronous reset with the command stuck in ISSUE
    do_ins(16'h0077, "pre_rst");
    core_hold = 1'b1;
    sw = 16'h0088;
    @(negedge clk);
    btn_ins = 1'b1;
    n = 0;
    while (!cmd_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_valid", 32'(cmd_valid), 32'(1));
    btn_ins = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_cmd_valid", 32'(cmd_valid), 32'(0));
    chk("arst_count", 32'(count), 32'(0));
    chk("arst_empty", 32'(empty), 32'(1));
    chk("arst_last", 32'(last_key), 32'(0));
    repeat (3) @(negedge clk);
    core_hold = 1'b0;
    rst = 1'b1;
    exp_cnt = 0; exp_last = '0; exp_cmds++;
    repeat (12) @(negedge clk);
    do_ins(16'h0099, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
